// File: rtl/complex_dot_pipe.sv
// rtl/complex_dot_pipe.sv - pipelined complex fixed-point dot product with conj, rounding and saturation
// Stages: S1 multiply, S2 combine, S3 accumulate, S4 round/saturate into the result register.
module complex_dot_pipe #(
  parameter int W    = 8,
  parameter int LEN  = 4,
  parameter int FRAC = 0,
  parameter int OW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  a_real,
  input  logic signed [W-1:0]  a_imag,
  input  logic signed [W-1:0]  b_real,
  input  logic signed [W-1:0]  b_imag,
  input  logic                 conj_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] result_real,
  output logic signed [OW-1:0] result_imag,
  output logic                 result_sat
);
  localparam int ACC_W = 2*W + 2 + $clog2(LEN);
  localparam int CW    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PW    = 2*W;
  localparam int TW    = 2*W + 1;
  localparam int RW    = (ACC_W + 1 > OW + 1) ? ACC_W + 1 : OW + 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic signed [RW-1:0] HALF =
    (FRAC > 0) ? (RW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] MAXV = (RW'(1) << (OW - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic                    en;
  logic [CW-1:0]           in_cnt, cnt;
  logic                    conj_vec, first_beat, conj_now;
  logic                    s1_valid, s1_conj;
  logic signed [PW-1:0]    rr, ii, ri, ir;
  logic                    s2_valid;
  logic signed [TW-1:0]    s2_re, s2_im;
  logic signed [ACC_W-1:0] acc_re, acc_im, sum_re, sum_im, fin_re, fin_im;
  logic                    fin_valid, last_term;
  logic [OW:0]             sc_re, sc_im;

  assign en         = !out_valid || out_ready;
  assign in_ready   = en;
  assign first_beat = (in_cnt == '0);
  assign conj_now   = first_beat ? conj_b : conj_vec;
  assign last_term  = (cnt == LAST);

  // The first term of a vector replaces the accumulator rather than adding to it.
  assign sum_re = ((cnt == '0) ? '0 : acc_re) + ACC_W'(s2_re);
  assign sum_im = ((cnt == '0) ? '0 : acc_im) + ACC_W'(s2_im);

  // Arithmetic shift after adding half makes negative ties round toward +inf.
  function automatic logic [OW:0] round_sat(input logic signed [ACC_W-1:0] s);
    logic signed [RW-1:0] x;
    x = (RW'(s) + HALF) >>> FRAC;
    if (x > MAXV)      round_sat = {1'b1, MAXV[OW-1:0]};
    else if (x < MINV) round_sat = {1'b1, MINV[OW-1:0]};
    else               round_sat = {1'b0, x[OW-1:0]};
  endfunction

  assign sc_re = round_sat(fin_re);
  assign sc_im = round_sat(fin_im);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt      <= '0;
      conj_vec    <= 1'b0;
      s1_valid    <= 1'b0;
      s1_conj     <= 1'b0;
      rr          <= '0;
      ii          <= '0;
      ri          <= '0;
      ir          <= '0;
      s2_valid    <= 1'b0;
      s2_re       <= '0;
      s2_im       <= '0;
      cnt         <= '0;
      acc_re      <= '0;
      acc_im      <= '0;
      fin_valid   <= 1'b0;
      fin_re      <= '0;
      fin_im      <= '0;
      out_valid   <= 1'b0;
      result_real <= '0;
      result_imag <= '0;
      result_sat  <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        rr      <= PW'(a_real) * PW'(b_real);
        ii      <= PW'(a_imag) * PW'(b_imag);
        ri      <= PW'(a_real) * PW'(b_imag);
        ir      <= PW'(a_imag) * PW'(b_real);
        s1_conj <= conj_now;
        if (first_beat) conj_vec <= conj_b;
        in_cnt  <= (in_cnt == LAST) ? '0 : in_cnt + CW'(1);
      end

      s2_valid <= s1_valid;
      s2_re    <= s1_conj ? TW'(rr) + TW'(ii) : TW'(rr) - TW'(ii);
      s2_im    <= s1_conj ? TW'(ir) - TW'(ri) : TW'(ir) + TW'(ri);

      fin_valid <= s2_valid && last_term;
      if (s2_valid) begin
        acc_re <= sum_re;
        acc_im <= sum_im;
        cnt    <= last_term ? '0 : cnt + CW'(1);
        if (last_term) begin
          fin_re <= sum_re;
          fin_im <= sum_im;
        end
      end

      // en here means the held result is either absent or being consumed.
      if (fin_valid) begin
        result_real <= sc_re[OW-1:0];
        result_imag <= sc_im[OW-1:0];
        result_sat  <= sc_re[OW] | sc_im[OW];
        out_valid   <= 1'b1;
      end else begin
        out_valid   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_complex_dot_pipe.sv
// tb/tb_complex_dot_pipe.sv - bench for complex_dot_pipe
// Three instances: LEN=1/FRAC=0, LEN=4/FRAC=0, LEN=1/FRAC=4, all W=8, OW=16.
module tb_complex_dot_pipe;
  localparam int LENS  [3] = '{1, 4, 1};
  localparam int FRACS [3] = '{0, 0, 4};

  typedef struct { int re; int im; bit sat; } res_t;
  typedef struct { int d; int ar; int ai; int br; int bi; bit cj; int re; int im; bit sat; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv [3], ir [3], cj [3], ov [3], ordy [3], rsat [3];
  logic signed [7:0]  ar [3], ai [3], br [3], bi [3];
  logic signed [15:0] rre [3], rim [3];

  int checks = 0;
  int fails  = 0;

  res_t   exp_q [3][$];
  int     m_cnt [3];
  bit     m_conj [3];
  longint m_re [3], m_im [3];
  res_t   sb_r;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    complex_dot_pipe #(.W(8), .LEN(LENS[g]), .FRAC(FRACS[g]), .OW(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]),
      .a_real(ar[g]), .a_imag(ai[g]), .b_real(br[g]), .b_imag(bi[g]), .conj_b(cj[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]),
      .result_real(rre[g]), .result_imag(rim[g]), .result_sat(rsat[g])
    );
  end

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Reference: exact complex sum, then floor((s + half) / 2^FRAC), then clip to 16 bits.
  function automatic int scale_clip(longint s, int f, output bit sat);
    longint x;
    x = s;
    if (f > 0) x = (x + (longint'(1) << (f - 1))) >>> f;
    sat = 1'b0;
    if (x > 32767) begin x = 32767; sat = 1'b1; end
    if (x < -32768) begin x = -32768; sat = 1'b1; end
    return int'(x);
  endfunction

  task automatic model_beat(int d, int a_r, int a_i, int b_r, int b_i, bit c);
    res_t r;
    bit s0, s1;
    if (m_cnt[d] == 0) begin
      m_conj[d] = c; m_re[d] = 0; m_im[d] = 0;
    end
    if (m_conj[d]) begin
      m_re[d] += longint'(a_r * b_r + a_i * b_i);
      m_im[d] += longint'(a_i * b_r - a_r * b_i);
    end else begin
      m_re[d] += longint'(a_r * b_r - a_i * b_i);
      m_im[d] += longint'(a_i * b_r + a_r * b_i);
    end
    m_cnt[d]++;
    if (m_cnt[d] == LENS[d]) begin
      m_cnt[d] = 0;
      r.re  = scale_clip(m_re[d], FRACS[d], s0);
      r.im  = scale_clip(m_im[d], FRACS[d], s1);
      r.sat = s0 | s1;
      exp_q[d].push_back(r);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(int d, int a_r, int a_i, int b_r, int b_i, bit c);
    int tmo = 0;
    iv[d] = 1'b1; ar[d] = 8'(a_r); ai[d] = 8'(a_i); br[d] = 8'(b_r); bi[d] = 8'(b_i); cj[d] = c;
    #1;
    while (!ir[d] && tmo < 200) begin
      @(negedge clk); #1; tmo++;
    end
    if (!ir[d]) begin
      check("accept_timeout", ir[d], 1);
      return;
    end
    model_beat(d, a_r, a_i, b_r, b_i, c);
    @(negedge clk);
  endtask

  task automatic drain(int d);
    int t = 0;
    while (exp_q[d].size() > 0 && t < 100) begin @(negedge clk); t++; end
    check("drain_empty", exp_q[d].size(), 0);
  endtask

  task automatic run_vec(vec_t v);
    int lat = 0;
    for (int n = 0; n < LENS[v.d]; n++) send_beat(v.d, v.ar, v.ai, v.br, v.bi, v.cj);
    iv[v.d] = 1'b0;
    while (!ov[v.d] && lat < 20) begin @(negedge clk); lat++; end
    check("latency", lat, 3);
    check("vec_re", rre[v.d], v.re);
    check("vec_im", rim[v.d], v.im);
    check("vec_sat", rsat[v.d], v.sat);
    @(negedge clk);
  endtask

  task automatic rand_run(int d, int nvec);
    bit done = 1'b0;
    fork
      begin
        for (int n = 0; n < nvec * LENS[d]; n++) begin
          while ($urandom_range(0, 3) == 0) begin iv[d] = 1'b0; @(negedge clk); end
          send_beat(d, rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)));
        end
        iv[d] = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin ordy[d] = ($urandom_range(0, 2) != 0); @(negedge clk); end
        ordy[d] = 1'b1;
      end
    join
    drain(d);
  endtask

  // Scoreboard: every consumed result must be the next one the model expects.
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 3; d++) begin
      if (!rst && ov[d] && ordy[d]) begin
        if (exp_q[d].size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          sb_r = exp_q[d].pop_front();
          check("sb_re", rre[d], sb_r.re);
          check("sb_im", rim[d], sb_r.im);
          check("sb_sat", rsat[d], sb_r.sat);
        end
      end
    end
  end

  initial begin
    vec_t tbl [$];
    int t, n, prev;
    logic signed [15:0] s_re, s_im;

    for (int d = 0; d < 3; d++) begin
      iv[d] = 0; ordy[d] = 1; cj[d] = 0; ar[d] = 0; ai[d] = 0; br[d] = 0; bi[d] = 0;
      m_cnt[d] = 0;
    end

    tbl.push_back('{0,    3,    4,    2,    2, 1'b0,     -2,  14, 1'b0});
    tbl.push_back('{0,    3,    4,    2,    2, 1'b1,     14,   2, 1'b0});
    tbl.push_back('{0, -128, -128, -128, -128, 1'b0,      0, 32767, 1'b1});
    tbl.push_back('{1,    3,    4,    2,    2, 1'b0,     -8,  56, 1'b0});
    tbl.push_back('{1, -128,    0, -128,    0, 1'b0,  32767,   0, 1'b1});
    tbl.push_back('{1, -128,    0,  127,    0, 1'b0, -32768,   0, 1'b1});
    tbl.push_back('{2,    5,    0,    5,    0, 1'b0,      2,   0, 1'b0});
    tbl.push_back('{2,    5,    0,   -5,    0, 1'b0,     -2,   0, 1'b0});
    tbl.push_back('{2,    8,    0,    1,    0, 1'b0,      1,   0, 1'b0});
    tbl.push_back('{2,   -8,    0,    1,    0, 1'b0,      0,   0, 1'b0});

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", ov[d], 0);
      check("rst_in_ready", ir[d], 1);
      check("rst_result", {rre[d], rim[d]}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Ten back-to-back vectors on LEN=4: one result every 4 cycles.
    n = 0; prev = -1;
    fork
      begin
        for (int k = 0; k < 40; k++) send_beat(1, rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)));
        iv[1] = 1'b0;
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (ov[1]) begin
            if (prev >= 0) check("result_gap", c - prev, 4);
            prev = c; n++;
          end
        end
      end
    join
    check("result_count", n, 10);
    drain(1);

    // Back-pressure: hold a result, keep offering beats, then release.
    ordy[1] = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send_beat(1, rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)));
        iv[1] = 1'b0;
      end
      begin
        t = 0;
        while (!ov[1] && t < 50) begin @(negedge clk); t++; end
        check("bp_pending", ov[1], 1);
        s_re = rre[1]; s_im = rim[1];
        repeat (20) begin
          @(negedge clk);
          check("bp_in_ready", ir[1], 0);
          check("bp_hold_re", rre[1], s_re);
          check("bp_hold_im", rim[1], s_im);
        end
        ordy[1] = 1'b1;
      end
    join
    drain(1);

    rand_run(0, 20);
    rand_run(1, 25);
    rand_run(2, 30);

    // Reset with a result held and a partial vector in flight.
    ordy[1] = 1'b0;
    for (int k = 0; k < 6; k++) send_beat(1, rnd(), rnd(), rnd(), rnd(), 1'b0);
    iv[1] = 1'b0;
    t = 0;
    while (!ov[1] && t < 20) begin @(negedge clk); t++; end
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", ov[1], 0);
    check("mid_rst_re", rre[1], 0);
    check("mid_rst_im", rim[1], 0);
    check("mid_rst_sat", rsat[1], 0);
    check("mid_rst_in_ready", ir[1], 1);
    for (int d = 0; d < 3; d++) begin m_cnt[d] = 0; exp_q[d].delete(); end
    @(negedge clk);
    rst = 1'b0;
    ordy[1] = 1'b1;
    run_vec('{1, 1, 2, 3, -1, 1'b0, 20, 20, 1'b0});
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
